// File: rtl/wb_port_arbiter_pkg.sv
// Shared defaults and grant encoding for the register-file write-port arbiter.
package wb_port_arbiter_pkg;

  localparam int REG_FILE_WIDTH = 32;
  localparam int ADDR_WIDTH     = 5;
  localparam int WBARB_DEPTH    = 4;
  localparam int WBARB_MAX_WAIT = 8;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_PIPE = 2'd1,
    GNT_LONG = 2'd2
  } grant_e;

endpackage

// File: rtl/wb_pending_fifo.sv
// Circular pending queue for long-latency results; each entry carries a live bit
// that a younger pipeline write to the same register can clear in parallel.
module wb_pending_fifo
  import wb_port_arbiter_pkg::*;
#(
  parameter int DATA_W = REG_FILE_WIDTH,
  parameter int ADDR_W = ADDR_WIDTH,
  parameter int DEPTH  = WBARB_DEPTH,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_push,
  input  logic [ADDR_W-1:0] i_push_addr,
  input  logic [DATA_W-1:0] i_push_data,
  input  logic              i_push_killed,
  input  logic              i_pop,
  input  logic              i_kill_en,
  input  logic [ADDR_W-1:0] i_kill_addr,
  output logic              o_head_valid,
  output logic              o_head_killed,
  output logic [ADDR_W-1:0] o_head_addr,
  output logic [DATA_W-1:0] o_head_data,
  output logic [CNT_W-1:0]  o_count,
  output logic              o_full
);

  logic [ADDR_W-1:0] r_addr [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [DEPTH-1:0]  r_live;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              w_empty;

  always_ff @(posedge clk) begin
    if (i_push) begin
      r_addr[r_wr_ptr] <= i_push_addr;
      r_data[r_wr_ptr] <= i_push_data;
    end
  end

  // Kill first so a same-cycle push into a freed slot keeps its own live bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_live   <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (i_kill_en && (r_addr[i] == i_kill_addr)) r_live[i] <= 1'b0;
      end
      if (i_push) begin
        r_live[r_wr_ptr] <= !i_push_killed;
        r_wr_ptr         <= r_wr_ptr + PTR_W'(1);
      end
      if (i_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign w_empty       = (r_count == '0);
  assign o_head_valid  = !w_empty && r_live[r_rd_ptr];
  assign o_head_killed = !w_empty && !r_live[r_rd_ptr];
  assign o_head_addr   = r_addr[r_rd_ptr];
  assign o_head_data   = r_data[r_rd_ptr];
  assign o_count       = r_count;
  assign o_full        = (r_count == CNT_W'(DEPTH));

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the single register-file write port between the WB pipeline path and
// queued long-latency results, with an aging override that stalls WB for one cycle.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int DATA_W   = REG_FILE_WIDTH,
  parameter int ADDR_W   = ADDR_WIDTH,
  parameter int DEPTH    = WBARB_DEPTH,
  parameter int MAX_WAIT = WBARB_MAX_WAIT,
  localparam int CNT_W   = $clog2(DEPTH) + 1,
  localparam int AGE_W   = $clog2(MAX_WAIT + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p_we,
  input  logic [ADDR_W-1:0] p_addr,
  input  logic [DATA_W-1:0] p_data,
  input  logic              l_valid,
  output logic              l_ready,
  input  logic [ADDR_W-1:0] l_addr,
  input  logic [DATA_W-1:0] l_data,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_data,
  output logic              wb_stall,
  output logic [CNT_W-1:0]  q_count
);

  function automatic logic [AGE_W-1:0] age_sat_inc(input logic [AGE_W-1:0] a);
    return (a == AGE_W'(MAX_WAIT)) ? a : a + AGE_W'(1);
  endfunction

  logic              w_p_req;
  logic              w_push;
  logic              w_push_killed;
  logic              w_pop;
  logic              w_stall;
  logic              w_kill_en;
  logic              w_head_valid;
  logic              w_head_killed;
  logic [ADDR_W-1:0] w_head_addr;
  logic [DATA_W-1:0] w_head_data;
  logic [CNT_W-1:0]  w_count;
  logic              w_full;
  logic              w_aged;
  grant_e            w_grant;
  logic [AGE_W-1:0]  r_age;

  assign w_p_req       = p_we && (p_addr != '0);
  assign l_ready       = !reset && !w_full;
  assign w_push        = l_valid && l_ready && (l_addr != '0);
  assign w_kill_en     = (w_grant == GNT_PIPE);
  assign w_push_killed = w_kill_en && (l_addr == p_addr);
  assign w_aged        = (r_age == AGE_W'(MAX_WAIT));

  wb_pending_fifo #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk           (clk),
    .reset         (reset),
    .i_push        (w_push),
    .i_push_addr   (l_addr),
    .i_push_data   (l_data),
    .i_push_killed (w_push_killed),
    .i_pop         (w_pop),
    .i_kill_en     (w_kill_en),
    .i_kill_addr   (p_addr),
    .o_head_valid  (w_head_valid),
    .o_head_killed (w_head_killed),
    .o_head_addr   (w_head_addr),
    .o_head_data   (w_head_data),
    .o_count       (w_count),
    .o_full        (w_full)
  );

  // A killed head drains without using the port, so the pipeline may still write.
  always_comb begin
    w_grant = GNT_NONE;
    w_pop   = 1'b0;
    w_stall = 1'b0;
    if (!reset) begin
      if (w_head_killed) begin
        w_pop = 1'b1;
        if (w_p_req) w_grant = GNT_PIPE;
      end else if (w_head_valid && w_aged) begin
        w_grant = GNT_LONG;
        w_pop   = 1'b1;
        w_stall = w_p_req;
      end else if (w_head_valid && !w_p_req) begin
        w_grant = GNT_LONG;
        w_pop   = 1'b1;
      end else if (w_p_req) begin
        w_grant = GNT_PIPE;
      end
    end
  end

  assign rf_we    = (w_grant != GNT_NONE);
  assign rf_addr  = (w_grant == GNT_LONG) ? w_head_addr : p_addr;
  assign rf_data  = (w_grant == GNT_LONG) ? w_head_data : p_data;
  assign wb_stall = w_stall;
  assign q_count  = reset ? '0 : w_count;

  always_ff @(posedge clk) begin
    if (reset || w_pop || (w_count == '0)) begin
      r_age <= '0;
    end else if (w_head_valid) begin
      r_age <= age_sat_inc(r_age);
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: queue-level reference model checked every cycle,
// plus literal expectations for each scenario.
module tb_wb_port_arbiter;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 4;
  localparam int MAXW  = 8;

  logic          clk;
  logic          reset;
  logic          p_we;
  logic [AW-1:0] p_addr;
  logic [DW-1:0] p_data;
  logic          l_valid;
  logic          l_ready;
  logic [AW-1:0] l_addr;
  logic [DW-1:0] l_data;
  logic          rf_we;
  logic [AW-1:0] rf_addr;
  logic [DW-1:0] rf_data;
  logic          wb_stall;
  logic [2:0]    q_count;

  wb_port_arbiter #(
    .DATA_W   (DW),
    .ADDR_W   (AW),
    .DEPTH    (DEPTH),
    .MAX_WAIT (MAXW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .p_we     (p_we),
    .p_addr   (p_addr),
    .p_data   (p_data),
    .l_valid  (l_valid),
    .l_ready  (l_ready),
    .l_addr   (l_addr),
    .l_data   (l_data),
    .rf_we    (rf_we),
    .rf_addr  (rf_addr),
    .rf_data  (rf_data),
    .wb_stall (wb_stall),
    .q_count  (q_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: ordered list of pending results plus wait counter.
  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    bit            killed;
  } ent_t;

  ent_t mq[$];
  int   m_age = 0;
  bit   m_preq, m_gp, m_gl, m_pop, m_stall, m_lready;
  int   m_cnt;

  always @(negedge clk) begin
    if (reset) begin
      check("rst_rf_we", {31'd0, rf_we}, 32'd0);
      check("rst_stall", {31'd0, wb_stall}, 32'd0);
      check("rst_l_ready", {31'd0, l_ready}, 32'd0);
      check("rst_q_count", {29'd0, q_count}, 32'd0);
      mq.delete();
      m_age = 0;
    end else begin
      m_preq   = p_we && (p_addr != 0);
      m_cnt    = mq.size();
      m_lready = (m_cnt < DEPTH);
      m_gp = 0; m_gl = 0; m_pop = 0; m_stall = 0;
      if (m_cnt > 0 && mq[0].killed) begin
        m_pop = 1;
        m_gp  = m_preq;
      end else if (m_cnt > 0 && m_age == MAXW) begin
        m_gl = 1; m_pop = 1; m_stall = m_preq;
      end else if (m_cnt > 0 && !m_preq) begin
        m_gl = 1; m_pop = 1;
      end else if (m_preq) begin
        m_gp = 1;
      end

      check("mdl_rf_we", {31'd0, rf_we}, {31'd0, (m_gp || m_gl)});
      if (m_gl) begin
        check("mdl_l_addr", {27'd0, rf_addr}, {27'd0, mq[0].a});
        check("mdl_l_data", rf_data, mq[0].d);
      end
      if (m_gp) begin
        check("mdl_p_addr", {27'd0, rf_addr}, {27'd0, p_addr});
        check("mdl_p_data", rf_data, p_data);
      end
      check("mdl_stall", {31'd0, wb_stall}, {31'd0, m_stall});
      check("mdl_l_ready", {31'd0, l_ready}, {31'd0, m_lready});
      check("mdl_q_count", {29'd0, q_count}, 32'(m_cnt));

      if (m_gp) begin
        foreach (mq[i]) if (mq[i].a == p_addr) mq[i].killed = 1;
      end
      if (m_pop) void'(mq.pop_front());
      if (m_pop || m_cnt == 0) m_age = 0;
      else if (m_age < MAXW) m_age++;
      if (l_valid && m_lready && l_addr != 0)
        mq.push_back('{a: l_addr, d: l_data, killed: (m_gp && l_addr == p_addr)});
    end
  end

  bit r4_bad  = 0;
  bit r15_seen = 0;
  always @(negedge clk) begin
    if (rf_we && rf_addr == 5'd4 && rf_data == 32'h1) r4_bad = 1;
    if (rf_we && rf_addr == 5'd15) r15_seen = 1;
  end

  task automatic drive(input bit pwe, input logic [AW-1:0] pa, input logic [DW-1:0] pd,
                       input bit lv, input logic [AW-1:0] la, input logic [DW-1:0] ld);
    @(posedge clk);
    #1;
    p_we = pwe; p_addr = pa; p_data = pd;
    l_valid = lv; l_addr = la; l_data = ld;
    #1;
  endtask

  int stall_cnt;
  int stall_idx;

  initial begin
    reset = 1'b1;
    p_we = 1'b1; p_addr = 5'd5; p_data = 32'hAA;
    l_valid = 1'b1; l_addr = 5'd2; l_data = 32'h22;

    // Reset held with requests present
    repeat (3) begin
      @(posedge clk); #2;
      check("t1_l_ready", {31'd0, l_ready}, 32'd0);
      check("t1_rf_we", {31'd0, rf_we}, 32'd0);
      check("t1_q_count", {29'd0, q_count}, 32'd0);
    end
    @(posedge clk); #1;
    reset = 1'b0; p_we = 1'b0; l_valid = 1'b0;
    #1;
    check("t1_post_l_ready", {31'd0, l_ready}, 32'd1);
    check("t1_post_q_count", {29'd0, q_count}, 32'd0);

    // Pipeline only
    repeat (4) begin
      drive(1, 5'd5, 32'hAA, 0, 5'd0, 32'h0);
      check("t2_rf_we", {31'd0, rf_we}, 32'd1);
      check("t2_rf_addr", {27'd0, rf_addr}, 32'd5);
      check("t2_rf_data", rf_data, 32'hAA);
      check("t2_stall", {31'd0, wb_stall}, 32'd0);
    end

    // Single L result, no bypass
    drive(0, 5'd0, 32'h0, 1, 5'd3, 32'h11);
    check("t3_no_bypass", {31'd0, rf_we}, 32'd0);
    drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    check("t3_rf_we", {31'd0, rf_we}, 32'd1);
    check("t3_rf_addr", {27'd0, rf_addr}, 32'd3);
    check("t3_rf_data", rf_data, 32'h11);
    drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    check("t3_q_count", {29'd0, q_count}, 32'd0);

    // Register 0 is neither a pipeline request nor a queued write
    drive(1, 5'd0, 32'h55, 1, 5'd0, 32'h66);
    check("r0_rf_we", {31'd0, rf_we}, 32'd0);
    check("r0_l_ready", {31'd0, l_ready}, 32'd1);
    drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    check("r0_q_count", {29'd0, q_count}, 32'd0);
    check("r0_rf_we_next", {31'd0, rf_we}, 32'd0);

    // Aging override
    stall_cnt = 0; stall_idx = -1;
    for (int i = 0; i < 12; i++) begin
      drive(1, 5'd9, 32'h99, (i == 0), 5'd7, 32'h77);
      if (wb_stall) begin stall_cnt++; stall_idx = i; end
      if (i == 9) begin
        check("t4_forced_addr", {27'd0, rf_addr}, 32'd7);
        check("t4_forced_data", rf_data, 32'h77);
      end
      if (i == 10) begin
        check("t4_follow_addr", {27'd0, rf_addr}, 32'd9);
        check("t4_follow_stall", {31'd0, wb_stall}, 32'd0);
      end
    end
    check("t4_stall_cnt", 32'(stall_cnt), 32'd1);
    check("t4_stall_idx", 32'(stall_idx), 32'd9);

    // WAW kill
    drive(1, 5'd10, 32'hA0, 1, 5'd4, 32'h1);
    drive(1, 5'd10, 32'hA0, 1, 5'd6, 32'h2);
    drive(1, 5'd4, 32'h3, 0, 5'd0, 32'h0);
    check("t5_p_addr", {27'd0, rf_addr}, 32'd4);
    check("t5_p_data", rf_data, 32'h3);
    drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    check("t5_killed_no_we", {31'd0, rf_we}, 32'd0);
    check("t5_killed_count", {29'd0, q_count}, 32'd2);
    drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    check("t5_r6_addr", {27'd0, rf_addr}, 32'd6);
    check("t5_r6_data", rf_data, 32'h2);
    check("t5_r4_not_stale", {31'd0, r4_bad}, 32'd0);

    // Full queue
    for (int i = 0; i < 11; i++) begin
      drive(1, 5'd9, 32'h90, (i < 9), (i < 4) ? AW'(11 + i) : 5'd15, 32'h100 + 32'(i));
      if (i == 4) begin
        check("t6_full_count", {29'd0, q_count}, 32'd4);
        check("t6_full_ready", {31'd0, l_ready}, 32'd0);
      end
      if (i == 9) begin
        check("t6_forced_stall", {31'd0, wb_stall}, 32'd1);
        check("t6_forced_addr", {27'd0, rf_addr}, 32'd11);
        check("t6_ready_still_low", {31'd0, l_ready}, 32'd0);
      end
      if (i == 10) begin
        check("t6_ready_rise", {31'd0, l_ready}, 32'd1);
        check("t6_count_after", {29'd0, q_count}, 32'd3);
      end
    end
    repeat (4) drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    check("t6_drained", {29'd0, q_count}, 32'd0);
    check("t6_no_r15", {31'd0, r15_seen}, 32'd0);

    drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
